dcache_way_array: RTL and testbench

DCACHE_WAY_ARRAY -- requirements
Module: dcache_way_array

---
 rtl/dcache_way_array.sv | 207 ++++++++++++++++++++
 tb/tb_dcache_way_array.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_way_array.sv
// rtl/dcache_way_array.sv - set-associative tag/data way array with round-robin victim select
// Optional set-by-set flush engine enabled by DCACHE_WAY_ARRAY_FLUSH_EN.
module dcache_way_array #(
    parameter int TAG_LEN = 20,
    parameter int WAY_NUM = 2,
    parameter int SET_NUM = 64,
    localparam int IDX_LEN = $clog2(SET_NUM),
    localparam int WAY_LEN = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [IDX_LEN-1:0] req_index,
    input  logic [TAG_LEN-1:0] req_tag,
    input  logic [WAY_LEN-1:0] req_way,
    input  logic [127:0]       req_wdata,
    input  logic [127:0]       req_wmask,
    input  logic               req_dirty,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic [WAY_LEN-1:0] resp_way,
    output logic [127:0]       resp_data,
    output logic               resp_dirty,
    output logic [WAY_LEN-1:0] victim_way,
    output logic               victim_valid,
    output logic               victim_dirty,
    output logic [TAG_LEN-1:0] victim_tag,
    input  logic               flush_start,
    output logic               flush_busy,
    output logic               flush_done
);
    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b01;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic [1:0] OP_INV    = 2'b11;

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    state_t                          state_q, state_d;
    logic [IDX_LEN-1:0]              flush_cnt_q, flush_cnt_d;
    logic [WAY_NUM-1:0][SET_NUM-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [SET_NUM-1:0][WAY_LEN-1:0] ptr_q, ptr_d;
    logic [TAG_LEN-1:0]              tag_q  [WAY_NUM][SET_NUM];
    logic [127:0]                    data_q [WAY_NUM][SET_NUM];

    logic               req_fire, tag_we, data_we, lu_hit;
    logic [127:0]       line_d;
    logic [WAY_LEN-1:0] lu_way, vic_way;

    logic               resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d, resp_dirty_q, resp_dirty_d;
    logic [WAY_LEN-1:0] resp_way_q, resp_way_d, victim_way_q, victim_way_d;
    logic [127:0]       resp_data_q, resp_data_d;
    logic               victim_valid_q, victim_valid_d, victim_dirty_q, victim_dirty_d;
    logic [TAG_LEN-1:0] victim_tag_q, victim_tag_d;

`ifdef DCACHE_WAY_ARRAY_FLUSH_EN
    assign req_ready  = (state_q == ST_IDLE) && !flush_start;
    assign flush_busy = (state_q == ST_FLUSH);
    assign flush_done = (state_q == ST_FLUSH) && (flush_cnt_q == IDX_LEN'(SET_NUM - 1));
`else
    logic unused_flush_start;
    assign unused_flush_start = flush_start;
    assign req_ready  = 1'b1;
    assign flush_busy = 1'b0;
    assign flush_done = 1'b0;
`endif
    assign req_fire = req_valid && req_ready;

    // Descending scan so the lowest-numbered matching way wins.
    always_comb begin
        lu_hit  = 1'b0;
        lu_way  = '0;
        vic_way = ptr_q[req_index];
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (valid_q[WAY_LEN'(w)][req_index] && (tag_q[WAY_LEN'(w)][req_index] == req_tag)) begin
                lu_hit = 1'b1;
                lu_way = WAY_LEN'(w);
            end
            if (!valid_q[WAY_LEN'(w)][req_index]) begin
                vic_way = WAY_LEN'(w);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        ptr_d       = ptr_q;
        tag_we      = 1'b0;
        data_we     = 1'b0;
        line_d      = (req_op == OP_FILL) ? req_wdata
                    : ((data_q[req_way][req_index] & ~req_wmask) | (req_wdata & req_wmask));
        if (req_fire) begin
            unique case (req_op)
                OP_FILL: begin
                    valid_d[req_way][req_index] = 1'b1;
                    dirty_d[req_way][req_index] = req_dirty;
                    tag_we                      = 1'b1;
                    data_we                     = 1'b1;
                    ptr_d[req_index] = (ptr_q[req_index] == WAY_LEN'(WAY_NUM - 1)) ? '0
                                     : ptr_q[req_index] + 1'b1;
                end
                OP_WRITE: begin
                    dirty_d[req_way][req_index] = 1'b1;
                    data_we                     = 1'b1;
                end
                OP_INV: begin
                    valid_d[req_way][req_index] = 1'b0;
                    dirty_d[req_way][req_index] = 1'b0;
                end
                default: ;
            endcase
        end
`ifdef DCACHE_WAY_ARRAY_FLUSH_EN
        if (state_q == ST_FLUSH) begin
            for (int w = 0; w < WAY_NUM; w++) begin
                valid_d[WAY_LEN'(w)][flush_cnt_q] = 1'b0;
                dirty_d[WAY_LEN'(w)][flush_cnt_q] = 1'b0;
            end
            flush_cnt_d = flush_cnt_q + 1'b1;
            if (flush_cnt_q == IDX_LEN'(SET_NUM - 1)) begin
                state_d = ST_IDLE;
            end
        end else if (flush_start) begin
            state_d = ST_FLUSH;
        end
`endif
    end

    always_comb begin
        resp_valid_d   = req_fire;
        resp_hit_d     = 1'b1;
        resp_way_d     = req_way;
        resp_data_d    = '0;
        resp_dirty_d   = 1'b0;
        victim_way_d   = victim_way_q;
        victim_valid_d = victim_valid_q;
        victim_dirty_d = victim_dirty_q;
        victim_tag_d   = victim_tag_q;
        if (req_op == OP_LOOKUP) begin
            resp_hit_d   = lu_hit;
            resp_way_d   = lu_way;
            resp_data_d  = lu_hit ? data_q[lu_way][req_index] : '0;
            resp_dirty_d = lu_hit && dirty_q[lu_way][req_index];
            if (req_fire) begin
                victim_way_d   = vic_way;
                victim_valid_d = valid_q[vic_way][req_index];
                victim_dirty_d = dirty_q[vic_way][req_index];
                victim_tag_d   = tag_q[vic_way][req_index];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            flush_cnt_q    <= '0;
            valid_q        <= '0;
            dirty_q        <= '0;
            ptr_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_hit_q     <= 1'b0;
            resp_dirty_q   <= 1'b0;
            victim_valid_q <= 1'b0;
            victim_dirty_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            valid_q        <= valid_d;
            dirty_q        <= dirty_d;
            ptr_q          <= ptr_d;
            resp_valid_q   <= resp_valid_d;
            resp_hit_q     <= resp_hit_d;
            resp_dirty_q   <= resp_dirty_d;
            victim_valid_q <= victim_valid_d;
            victim_dirty_q <= victim_dirty_d;
        end
    end

    // Tags, line data and response payload carry no reset.
    always_ff @(posedge clk) begin
        resp_way_q   <= resp_way_d;
        resp_data_q  <= resp_data_d;
        victim_way_q <= victim_way_d;
        victim_tag_q <= victim_tag_d;
        if (tag_we) begin
            tag_q[req_way][req_index] <= req_tag;
        end
        if (data_we) begin
            data_q[req_way][req_index] <= line_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_hit     = resp_hit_q;
    assign resp_way     = resp_way_q;
    assign resp_data    = resp_data_q;
    assign resp_dirty   = resp_dirty_q;
    assign victim_way   = victim_way_q;
    assign victim_valid = victim_valid_q;
    assign victim_dirty = victim_dirty_q;
    assign victim_tag   = victim_tag_q;
endmodule

// File: tb/tb_dcache_way_array.sv
// tb/tb_dcache_way_array.sv - scoreboard bench for dcache_way_array
module tb_dcache_way_array;
    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b01;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic [1:0] OP_INV    = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [5:0]   req_index = '0;
    logic [19:0]  req_tag = '0;
    logic [0:0]   req_way = '0;
    logic [127:0] req_wdata = '0;
    logic [127:0] req_wmask = '0;
    logic         req_dirty = 1'b0;
    logic         resp_valid, resp_hit, resp_dirty;
    logic [0:0]   resp_way;
    logic [127:0] resp_data;
    logic [0:0]   victim_way;
    logic         victim_valid, victim_dirty;
    logic [19:0]  victim_tag;
    logic         flush_start = 1'b0;
    logic         flush_busy, flush_done;

    dcache_way_array dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_index(req_index), .req_tag(req_tag), .req_way(req_way), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .req_dirty(req_dirty), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_data(resp_data), .resp_dirty(resp_dirty),
        .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
        .victim_tag(victim_tag), .flush_start(flush_start), .flush_busy(flush_busy),
        .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic         hit;
        logic         chk_way;
        logic [0:0]   way;
        logic         chk_data;
        logic [127:0] data;
        logic         dirty;
        logic         chk_vic;
        logic [0:0]   vway;
        logic         vvalid;
        logic         vdirty;
        logic [19:0]  vtag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            check("resp_expected", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("resp_cycle", 128'(cyc), 128'(mon_e.due));
                check("resp_hit", 128'(resp_hit), 128'(mon_e.hit));
                if (mon_e.chk_way) check("resp_way", 128'(resp_way), 128'(mon_e.way));
                if (mon_e.chk_data) begin
                    check("resp_data", resp_data, mon_e.data);
                    check("resp_dirty", 128'(resp_dirty), 128'(mon_e.dirty));
                end
                if (mon_e.chk_vic) begin
                    check("victim_way", 128'(victim_way), 128'(mon_e.vway));
                    check("victim_valid", 128'(victim_valid), 128'(mon_e.vvalid));
                    check("victim_dirty", 128'(victim_dirty), 128'(mon_e.vdirty));
                    if (mon_e.vvalid) check("victim_tag", 128'(victim_tag), 128'(mon_e.vtag));
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input int idx, input logic [19:0] tag, input int way,
                        input logic [127:0] wd, input logic [127:0] wm, input logic dty, input exp_t e);
        req_valid = 1'b1;
        req_op    = op;
        req_index = 6'(idx);
        req_tag   = tag;
        req_way   = 1'(way);
        req_wdata = wd;
        req_wmask = wm;
        req_dirty = dty;
        #1;
        check("req_ready", 128'(req_ready), 128'd1);
        e.due = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic lookup(input int idx, input logic [19:0] tag, input logic hit, input int way,
                          input logic [127:0] data, input logic dty, input int vway,
                          input logic vv, input logic vd, input logic [19:0] vt);
        exp_t e;
        e.due = 0; e.hit = hit; e.chk_way = hit; e.way = 1'(way);
        e.chk_data = 1'b1; e.data = data; e.dirty = dty;
        e.chk_vic = 1'b1; e.vway = 1'(vway); e.vvalid = vv; e.vdirty = vd; e.vtag = vt;
        send(OP_LOOKUP, idx, tag, 0, '0, '0, 1'b0, e);
    endtask

    task automatic modify(input logic [1:0] op, input int idx, input logic [19:0] tag, input int way,
                          input logic [127:0] wd, input logic [127:0] wm, input logic dty);
        exp_t e;
        e.due = 0; e.hit = 1'b1; e.chk_way = 1'b1; e.way = 1'(way);
        e.chk_data = 1'b0; e.data = '0; e.dirty = 1'b0;
        e.chk_vic = 1'b0; e.vway = '0; e.vvalid = 1'b0; e.vdirty = 1'b0; e.vtag = '0;
        send(op, idx, tag, way, wd, wm, dty, e);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a5, wr, exp_w;
        int busy_n, done_n, done_at;
        a5    = {16{8'hA5}};
        wr    = {{12{8'hFF}}, 32'h11223344};
        exp_w = {{12{8'hA5}}, 32'h11223344};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_resp_valid", 128'(resp_valid), 128'd0);
        check("rst_flush_busy", 128'(flush_busy), 128'd0);
        check("rst_flush_done", 128'(flush_done), 128'd0);
        check("rst_req_ready", 128'(req_ready), 128'd1);

        lookup(5, 20'h123, 1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0, '0);
        modify(OP_FILL, 5, 20'h123, 1, a5, '0, 1'b0);
        lookup(5, 20'h123, 1'b1, 1, a5, 1'b0, 0, 1'b0, 1'b0, '0);
        modify(OP_WRITE, 5, 20'h123, 1, wr, 128'hFFFF_FFFF, 1'b0);
        lookup(5, 20'h123, 1'b1, 1, exp_w, 1'b1, 0, 1'b0, 1'b0, '0);

        lookup(7, 20'h70, 1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0, '0);
        modify(OP_FILL, 7, 20'h70, 0, {8{16'h7070}}, '0, 1'b0);
        modify(OP_FILL, 7, 20'h71, 1, {8{16'h7171}}, '0, 1'b1);
        lookup(7, 20'h7FF, 1'b0, 0, '0, 1'b0, 0, 1'b1, 1'b0, 20'h70);
        modify(OP_FILL, 7, 20'h72, 0, {8{16'h7272}}, '0, 1'b1);
        lookup(7, 20'h7FF, 1'b0, 0, '0, 1'b0, 1, 1'b1, 1'b1, 20'h71);
        modify(OP_FILL, 7, 20'h73, 1, {8{16'h7373}}, '0, 1'b0);
        lookup(7, 20'h7FF, 1'b0, 0, '0, 1'b0, 0, 1'b1, 1'b1, 20'h72);
        lookup(7, 20'h73, 1'b1, 1, {8{16'h7373}}, 1'b0, 0, 1'b1, 1'b1, 20'h72);

        modify(OP_FILL, 9, 20'h55, 1, {4{32'hD1D1_0001}}, '0, 1'b0);
        modify(OP_FILL, 9, 20'h55, 0, {4{32'hD0D0_0000}}, '0, 1'b1);
        lookup(9, 20'h55, 1'b1, 0, {4{32'hD0D0_0000}}, 1'b1, 0, 1'b1, 1'b1, 20'h55);

        modify(OP_FILL, 63, 20'hFFFFF, 0, {4{32'h6363_6363}}, '0, 1'b0);
        lookup(63, 20'hFFFFF, 1'b1, 0, {4{32'h6363_6363}}, 1'b0, 1, 1'b0, 1'b0, '0);

        modify(OP_INV, 5, 20'h0, 1, '0, '0, 1'b0);
        lookup(5, 20'h123, 1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0, '0);
        modify(OP_FILL, 5, 20'h200, 0, {4{32'h0000_0200}}, '0, 1'b0);
        lookup(5, 20'h999, 1'b0, 0, '0, 1'b0, 1, 1'b0, 1'b0, '0);
        lookup(7, 20'h72, 1'b1, 0, {8{16'h7272}}, 1'b1, 0, 1'b1, 1'b1, 20'h72);

`ifdef DCACHE_WAY_ARRAY_FLUSH_EN
        lookup(63, 20'hFFFFF, 1'b1, 0, {4{32'h6363_6363}}, 1'b0, 1, 1'b0, 1'b0, '0);
        flush_start = 1'b1;
        req_valid   = 1'b1;
        req_op      = OP_LOOKUP;
        req_index   = 6'd7;
        req_tag     = 20'h72;
        #1;
        check("flush_req_ready", 128'(req_ready), 128'd0);
        @(posedge clk); #1;
        flush_start = 1'b0;
        req_valid   = 1'b0;
        busy_n = 0; done_n = 0; done_at = 0;
        for (int i = 0; i < 200 && flush_busy === 1'b1; i++) begin
            busy_n++;
            if (flush_done === 1'b1) begin
                done_n++;
                done_at = busy_n;
            end
            if (i == 10) check("flush_mid_ready", 128'(req_ready), 128'd0);
            flush_start = (i == 10);
            @(posedge clk); #1;
        end
        flush_start = 1'b0;
        check("flush_busy_cycles", 128'(busy_n), 128'd64);
        check("flush_done_count", 128'(done_n), 128'd1);
        check("flush_done_last", 128'(done_at), 128'd64);
        check("flush_after_ready", 128'(req_ready), 128'd1);
        lookup(7, 20'h72, 1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0, '0);
        lookup(9, 20'h55, 1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0, '0);
        lookup(63, 20'hFFFFF, 1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0, '0);
        lookup(5, 20'h200, 1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0, '0);

        modify(OP_FILL, 30, 20'h30, 0, {4{32'h3030_3030}}, '0, 1'b1);
        modify(OP_FILL, 40, 20'h40, 1, {4{32'h4040_4040}}, '0, 1'b0);
        lookup(30, 20'h30, 1'b1, 0, {4{32'h3030_3030}}, 1'b1, 1, 1'b0, 1'b0, '0);
        flush_start = 1'b1;
        @(posedge clk); #1;
        flush_start = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(posedge clk); #1;
        end
        check("flush_busy_set30", 128'(flush_busy), 128'd1);
`else
        flush_start = 1'b1;
        lookup(63, 20'hFFFFF, 1'b1, 0, {4{32'h6363_6363}}, 1'b0, 1, 1'b0, 1'b0, '0);
        flush_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("noflush_busy", 128'(flush_busy), 128'd0);
            check("noflush_done", 128'(flush_done), 128'd0);
            @(posedge clk); #1;
        end
        modify(OP_FILL, 30, 20'h30, 0, {4{32'h3030_3030}}, '0, 1'b1);
        modify(OP_FILL, 40, 20'h40, 1, {4{32'h4040_4040}}, '0, 1'b0);
`endif

        rst       = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_LOOKUP;
        req_index = 6'd30;
        req_tag   = 20'h30;
        @(posedge clk); #1;
        check("rst_mid_busy", 128'(flush_busy), 128'd0);
        check("rst_mid_done", 128'(flush_done), 128'd0);
        check("rst_mid_ready", 128'(req_ready), 128'd1);
        check("rst_abort_resp", 128'(resp_valid), 128'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_no_late_resp", 128'(resp_valid), 128'd0);

        lookup(30, 20'h30, 1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0, '0);
        lookup(40, 20'h40, 1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0, '0);
        lookup(7, 20'h72, 1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0, '0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
